event_generator_delay_unit: RTL and testbench
=============================================

# event_generator_delay_unit

Parametrised successor to the event generator unit. Each of `NUM_CHANNELS` channels converts a task into an event after a programmable delay, with optional auto-repeat, a stop task and per-channel interrupt enable. It sits on the PAR bus behind the PCGC slave in the read-data chain and drives `events` toward the PPI bus. It runs entirely in the peripheral's PCP-0 clock domain.

## Interface
- `NUM_CHANNELS`, 8: channel count; 1..32.
- `DELAY_W`, 16: delay counter width; 1..31.
- `PAR_AW`, 12 / `PAR_DW`, 32 / `PAR_WW`, 4: PAR address, data and write-enable widths.
- `ID_TRIGGER_BASE`, 'h000: TRIGGER[n] at base+4n; write bit0=1 triggers.
- `ID_STOP_BASE`, 'h080: STOP[n] at base+4n; write bit0=1 stops.
- `ID_EVENT_BASE`, 'h100: EVENT[n] at base+4n; read flag; write 0 clears.
- `ID_DELAY_BASE`, 'h200: DELAY[n] at base+4n; bits[DELAY_W-1:0]=delay, bit31=REPEAT.
- `ID_INTEN`, 'h300: INTEN register, bit n per channel.
- `ck`, in, 1: clock.
- `arst`, in, 1: reset. Asynchronous, active-high.
- `parAddr`, in, PAR_AW: PAR address.
- `parDo`, in, PAR_DW: PAR write data.
- `parRe`, in, 1: PAR read enable.
- `parWe`, in, PAR_WW: PAR write enable. Any bit set = full-word write.
- `parDiMain` / `parDiSelectMain`, in, PAR_DW / 1: upstream read data chain.
- `parDi` / `parDiSelect`, out, PAR_DW / 1: chained read data.
- `tasks`, in, NUM_CHANNELS: hardware trigger pulses (PPI).
- `tasksStop`, in, NUM_CHANNELS: hardware stop pulses.
- `events`, out, NUM_CHANNELS: one-cycle event pulses, registered.
- `irq`, out, 1: `|(EVENT & INTEN)`.
- `busy`, out, 1: any channel RUN; used as the clock request.

## Operation
- Per-channel FSM with states IDLE and RUN, plus counter `cnt[DELAY_W]`.
- Trigger = `tasks[n]` OR PAR write to TRIGGER[n] with bit0=1.
- Stop = `tasksStop[n]` OR PAR write to STOP[n] with bit0=1.
- IDLE + trigger → RUN, `cnt`←DELAY[n].
- RUN + trigger (retrigger) → `cnt`←DELAY[n]. Any pending expiry is discarded.
- RUN, `cnt`≠0 → `cnt`−1.
- RUN, `cnt`==0 → fire:
  - `events[n]`=1 next cycle and EVENT[n] flag set.
  - REPEAT=1: reload DELAY[n] and stay in RUN.
  - REPEAT=0: go to IDLE.
- Stop in any state → IDLE. No fire that cycle.
- Simultaneous events on the same channel, same cycle:
  - Stop beats trigger.
  - Trigger beats fire.
  - Flag set beats software clear of EVENT[n].
- DELAY[n] writes take effect at the next load only. Running counts are unaffected.
- Counter underflow is impossible; it never decrements at 0.
- Reads are combinational.
  - `parDiSelect` = `parDiSelectMain` | (`parRe` & own address hit).
  - `parDi` = own data when own hit, else `parDiMain`.
  - TRIGGER/STOP read 0. Unmapped offsets are not a hit.
- Writes to unmapped or read-only bits are ignored. DELAY bits[30:DELAY_W] read 0.

## Timing
- Reset values:
  - `events`=0, `irq`=0, `busy`=0.
  - All FSMs IDLE, `cnt`=0.
  - EVENT=0, INTEN=0, DELAY=0 (REPEAT=0).
- Latency: trigger sampled at edge k → `events[n]` high for exactly one cycle after edge k+D+1.
  - D=0 gives a pulse after edge k+1.
- Repeat period is D+1 cycles.
- EVENT flag and `irq` rise in the same cycle as the `events` pulse.
- `irq` falls the cycle after a clearing write or an INTEN bit clear.
- `arst` mid-count returns the channel to IDLE immediately (asynchronous). No event fires after release until a new trigger.

## Structure
- Package `pa_EventGeneratorDelayUnit` holds:
  - the default parameter values and register offsets;
  - `typedef enum logic {IDLE, RUN} t_ChState`.
- Sub-module `event_generator_delay_channel` holds one channel: FSM, counter, DELAY/REPEAT register and EVENT flag. It is instantiated with generate-for over `NUM_CHANNELS`.
- The top level holds address decode, INTEN, the read mux, the chain, `irq` and `busy`.

## Test plan
- DELAY[0]=5, REPEAT=0, write TRIGGER[0] at edge k → `events[0]` pulse after edge k+6 only. EVENT[0] reads 1, `irq`=0 (INTEN=0).
- DELAY[2]=0, REPEAT=1, `tasks[2]` pulse → `events[2]` every cycle until `tasksStop[2]`. After the stop, no further pulses and `busy`=0.
- DELAY[1]=10, trigger at k, retrigger at k+4 → a single pulse after edge k+15.
- INTEN=0x8, DELAY[3]=2: fire → `irq`=1. Write EVENT[3]=0 in the same cycle as a second fire → flag stays 1. A later clear → `irq`=0 next cycle.
- Trigger and stop on channel 4 in the same cycle → stays IDLE with no pulse. All `NUM_CHANNELS`=32, DELAY_W=31 max: DELAY='h7FFFFFFF loads with no overflow.
- `arst` pulse at count 3 of 8 → after release, `events`=0 indefinitely, all registers at reset values, and `parDi` equals `parDiMain` for unmapped reads.

Source files
------------

// File: rtl/event_generator_delay_unit_pkg.sv
// Shared defaults, register map and channel state type for the delay event generator.
package pa_EventGeneratorDelayUnit;

   localparam int unsigned NUM_CHANNELS_DEF    = 8;
   localparam int unsigned DELAY_W_DEF         = 16;
   localparam int unsigned PAR_AW_DEF          = 12;
   localparam int unsigned PAR_DW_DEF          = 32;
   localparam int unsigned PAR_WW_DEF          = 4;

   localparam int unsigned ID_TRIGGER_BASE_DEF = 'h000;
   localparam int unsigned ID_STOP_BASE_DEF    = 'h080;
   localparam int unsigned ID_EVENT_BASE_DEF   = 'h100;
   localparam int unsigned ID_DELAY_BASE_DEF   = 'h200;
   localparam int unsigned ID_INTEN_DEF        = 'h300;

   // Bit position of the REPEAT flag inside a DELAY word.
   localparam int unsigned REPEAT_BIT          = 31;
   localparam int unsigned WORD_W              = 32;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } t_ChState;

   // Byte offset of register n in a per-channel register bank.
   function automatic int unsigned reg_offset(input int unsigned base, input int unsigned ch);
      return base + 4 * ch;
   endfunction

endpackage

// File: rtl/event_generator_delay_unit_channel.sv
// One delay channel: IDLE/RUN FSM, down-counter, DELAY/REPEAT register and EVENT flag.
module event_generator_delay_channel
   import pa_EventGeneratorDelayUnit::*;
#(
   parameter int unsigned DELAY_W = DELAY_W_DEF
) (
   input  logic               ck,
   input  logic               arst,
   input  logic               trig,
   input  logic               stop,
   input  logic               delay_we,
   input  logic [DELAY_W-1:0] delay_wdata,
   input  logic               rpt_wdata,
   input  logic               flag_clr,
   output logic               event_pulse,
   output logic               flag,
   output logic               running,
   output logic [DELAY_W-1:0] delay,
   output logic               rpt
);

   t_ChState           state_q;
   t_ChState           state_d;
   logic [DELAY_W-1:0] cnt_q;
   logic [DELAY_W-1:0] cnt_d;
   logic               fire_c;

   // State and counter register.
   always_ff @(posedge ck or posedge arst) begin
      if (arst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: stop beats trigger, trigger (reload) beats expiry.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fire_c  = 1'b0;
      case (state_q)
         IDLE: begin
            if (trig) begin
               state_d = RUN;
               cnt_d   = delay;
            end
         end
         RUN: begin
            if (trig) begin
               cnt_d = delay;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - DELAY_W'(1);
            end else begin
               fire_c = 1'b1;
               if (rpt) begin
                  cnt_d = delay;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (stop) begin
         state_d = IDLE;
         cnt_d   = '0;
         fire_c  = 1'b0;
      end
   end

   // Configuration, event pulse and sticky flag (a fire wins over a software clear).
   always_ff @(posedge ck or posedge arst) begin
      if (arst) begin
         delay       <= '0;
         rpt         <= 1'b0;
         flag        <= 1'b0;
         event_pulse <= 1'b0;
      end else begin
         if (delay_we) begin
            delay <= delay_wdata;
            rpt   <= rpt_wdata;
         end
         event_pulse <= fire_c;
         if (fire_c) begin
            flag <= 1'b1;
         end else if (flag_clr) begin
            flag <= 1'b0;
         end
      end
   end

   assign running = (state_q == RUN);

endmodule

// File: rtl/event_generator_delay_unit.sv
// Multi-channel delayed event generator on the PAR bus: decode, INTEN, read chain, irq/busy.
module event_generator_delay_unit
   import pa_EventGeneratorDelayUnit::*;
#(
   parameter int unsigned NUM_CHANNELS    = NUM_CHANNELS_DEF,
   parameter int unsigned DELAY_W         = DELAY_W_DEF,
   parameter int unsigned PAR_AW          = PAR_AW_DEF,
   parameter int unsigned PAR_DW          = PAR_DW_DEF,
   parameter int unsigned PAR_WW          = PAR_WW_DEF,
   parameter int unsigned ID_TRIGGER_BASE = ID_TRIGGER_BASE_DEF,
   parameter int unsigned ID_STOP_BASE    = ID_STOP_BASE_DEF,
   parameter int unsigned ID_EVENT_BASE   = ID_EVENT_BASE_DEF,
   parameter int unsigned ID_DELAY_BASE   = ID_DELAY_BASE_DEF,
   parameter int unsigned ID_INTEN        = ID_INTEN_DEF
) (
   input  logic                    ck,
   input  logic                    arst,
   input  logic [PAR_AW-1:0]       parAddr,
   input  logic [PAR_DW-1:0]       parDo,
   input  logic                    parRe,
   input  logic [PAR_WW-1:0]       parWe,
   input  logic [PAR_DW-1:0]       parDiMain,
   input  logic                    parDiSelectMain,
   output logic [PAR_DW-1:0]       parDi,
   output logic                    parDiSelect,
   input  logic [NUM_CHANNELS-1:0] tasks,
   input  logic [NUM_CHANNELS-1:0] tasksStop,
   output logic [NUM_CHANNELS-1:0] events,
   output logic                    irq,
   output logic                    busy
);

   logic                    wr;
   logic [NUM_CHANNELS-1:0] hit_trig;
   logic [NUM_CHANNELS-1:0] hit_stop;
   logic [NUM_CHANNELS-1:0] hit_event;
   logic [NUM_CHANNELS-1:0] hit_delay;
   logic                    hit_inten;
   logic                    rd_hit;
   logic [NUM_CHANNELS-1:0] trig;
   logic [NUM_CHANNELS-1:0] stop;
   logic [NUM_CHANNELS-1:0] delay_we;
   logic [NUM_CHANNELS-1:0] flag_clr;
   logic [NUM_CHANNELS-1:0] flag;
   logic [NUM_CHANNELS-1:0] running;
   logic [NUM_CHANNELS-1:0] rpt;
   logic [DELAY_W-1:0]      delay [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] inten;
   logic [WORD_W-1:0]       rd_word;
   logic                    unused_par;

   assign wr         = |parWe;
   assign unused_par = ^parDo;

   // Exact-address decode of every per-channel register and INTEN.
   always_comb begin
      hit_trig  = '0;
      hit_stop  = '0;
      hit_event = '0;
      hit_delay = '0;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
         hit_trig[i]  = (parAddr == PAR_AW'(reg_offset(ID_TRIGGER_BASE, i)));
         hit_stop[i]  = (parAddr == PAR_AW'(reg_offset(ID_STOP_BASE, i)));
         hit_event[i] = (parAddr == PAR_AW'(reg_offset(ID_EVENT_BASE, i)));
         hit_delay[i] = (parAddr == PAR_AW'(reg_offset(ID_DELAY_BASE, i)));
      end
      hit_inten = (parAddr == PAR_AW'(ID_INTEN));
      rd_hit    = hit_inten | (|hit_trig) | (|hit_stop) | (|hit_event) | (|hit_delay);
   end

   // Hardware and software commands merged per channel.
   always_comb begin
      trig     = tasks     | ({NUM_CHANNELS{wr &  parDo[0]}} & hit_trig);
      stop     = tasksStop | ({NUM_CHANNELS{wr &  parDo[0]}} & hit_stop);
      delay_we = {NUM_CHANNELS{wr}} & hit_delay;
      flag_clr = {NUM_CHANNELS{wr & ~parDo[0]}} & hit_event;
   end

   // Interrupt enable register.
   always_ff @(posedge ck or posedge arst) begin
      if (arst) begin
         inten <= '0;
      end else if (wr && hit_inten) begin
         inten <= parDo[NUM_CHANNELS-1:0];
      end
   end

   for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
      event_generator_delay_channel #(
         .DELAY_W(DELAY_W)
      ) u_ch (
         .ck          (ck),
         .arst        (arst),
         .trig        (trig[g]),
         .stop        (stop[g]),
         .delay_we    (delay_we[g]),
         .delay_wdata (parDo[DELAY_W-1:0]),
         .rpt_wdata   (parDo[REPEAT_BIT]),
         .flag_clr    (flag_clr[g]),
         .event_pulse (events[g]),
         .flag        (flag[g]),
         .running     (running[g]),
         .delay       (delay[g]),
         .rpt         (rpt[g])
      );
   end

   // Own read word; TRIGGER/STOP hit but return zero.
   always_comb begin
      rd_word = '0;
      if (hit_inten) begin
         rd_word[NUM_CHANNELS-1:0] = inten;
      end
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
         if (hit_event[i]) begin
            rd_word[0] = flag[i];
         end
         if (hit_delay[i]) begin
            rd_word[DELAY_W-1:0]  = delay[i];
            rd_word[REPEAT_BIT]   = rpt[i];
         end
      end
   end

   assign parDiSelect = parDiSelectMain | (parRe & rd_hit);
   assign parDi       = (parRe && rd_hit) ? PAR_DW'(rd_word) : parDiMain;
   assign irq         = |(flag & inten);
   assign busy        = |running;

endmodule

// File: tb/tb_event_generator_delay_unit.sv
// Directed plus randomized bench for event_generator_delay_unit with an absolute-time reference model.
module tb_event_generator_delay_unit;

   localparam int unsigned N   = 8;
   localparam int unsigned MN  = 32;
   localparam int unsigned MDW = 31;

   logic          ck;
   logic          arst;
   logic [11:0]   parAddr;
   logic [31:0]   parDo;
   logic          parRe;
   logic [3:0]    parWe;
   logic [31:0]   parDiMain;
   logic          parDiSelectMain;
   logic [31:0]   parDi;
   logic          parDiSelect;
   logic [N-1:0]  tasks;
   logic [N-1:0]  tasksStop;
   logic [N-1:0]  events;
   logic          irq;
   logic          busy;

   logic [MN-1:0] max_tasks;
   logic [MN-1:0] max_events;
   logic [31:0]   max_di;
   logic          max_sel;
   logic          max_irq;
   logic          max_busy;

   int tests = 0;
   int fails = 0;

   // Reference model: each running channel holds the absolute edge number of its next fire.
   bit           m_active [N];
   longint       m_next   [N];
   int unsigned  m_delay  [N];
   bit           m_rpt    [N];
   bit           m_flag   [N];
   bit [N-1:0]   m_inten;
   bit [N-1:0]   m_events;
   longint       edge_no;

   event_generator_delay_unit u_dut (
      .ck              (ck),
      .arst            (arst),
      .parAddr         (parAddr),
      .parDo           (parDo),
      .parRe           (parRe),
      .parWe           (parWe),
      .parDiMain       (parDiMain),
      .parDiSelectMain (parDiSelectMain),
      .parDi           (parDi),
      .parDiSelect     (parDiSelect),
      .tasks           (tasks),
      .tasksStop       (tasksStop),
      .events          (events),
      .irq             (irq),
      .busy            (busy)
   );

   event_generator_delay_unit #(
      .NUM_CHANNELS (MN),
      .DELAY_W      (MDW)
   ) u_max (
      .ck              (ck),
      .arst            (arst),
      .parAddr         (parAddr),
      .parDo           (parDo),
      .parRe           (parRe),
      .parWe           (parWe),
      .parDiMain       (parDiMain),
      .parDiSelectMain (parDiSelectMain),
      .parDi           (max_di),
      .parDiSelect     (max_sel),
      .tasks           (max_tasks),
      .tasksStop       (max_tasks),
      .events          (max_events),
      .irq             (max_irq),
      .busy            (max_busy)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
      end
   endtask

   function automatic bit addr_ch(input logic [11:0] a, input int unsigned base, output int unsigned ch);
      int unsigned off;
      ch = 0;
      if (32'(a) < base) return 1'b0;
      off = 32'(a) - base;
      if ((off % 4) != 0 || (off / 4) >= N) return 1'b0;
      ch = off / 4;
      return 1'b1;
   endfunction

   function automatic void model_reset();
      for (int n = 0; n < N; n++) begin
         m_active[n] = 1'b0;
         m_next[n]   = 0;
         m_delay[n]  = 0;
         m_rpt[n]    = 1'b0;
         m_flag[n]   = 1'b0;
      end
      m_inten  = '0;
      m_events = '0;
      edge_no  = 0;
   endfunction

   function automatic bit any_active();
      bit r = 1'b0;
      for (int n = 0; n < N; n++) r |= m_active[n];
      return r;
   endfunction

   function automatic bit [N-1:0] flag_vec();
      bit [N-1:0] v;
      for (int n = 0; n < N; n++) v[n] = m_flag[n];
      return v;
   endfunction

   // One clock edge of the reference model, using the inputs currently applied.
   function automatic void model_edge();
      bit [N-1:0]  trg;
      bit [N-1:0]  stp;
      bit [N-1:0]  clr;
      bit [N-1:0]  fire;
      int unsigned ch;
      bit          dly_we;
      int unsigned dly_ch;
      bit          ie_we;
      if (arst) begin
         model_reset();
         return;
      end
      trg = tasks; stp = tasksStop; clr = '0; fire = '0;
      dly_we = 1'b0; dly_ch = 0; ie_we = 1'b0;
      if (parWe != 4'h0) begin
         if (addr_ch(parAddr, 'h000, ch)) begin
            if (parDo[0]) trg[ch] = 1'b1;
         end else if (addr_ch(parAddr, 'h080, ch)) begin
            if (parDo[0]) stp[ch] = 1'b1;
         end else if (addr_ch(parAddr, 'h100, ch)) begin
            if (!parDo[0]) clr[ch] = 1'b1;
         end else if (addr_ch(parAddr, 'h200, ch)) begin
            dly_we = 1'b1;
            dly_ch = ch;
         end else if (parAddr == 12'h300) begin
            ie_we = 1'b1;
         end
      end
      for (int n = 0; n < N; n++) begin
         fire[n] = m_active[n] && (m_next[n] == edge_no) && !trg[n] && !stp[n];
         if (stp[n]) begin
            m_active[n] = 1'b0;
         end else if (trg[n]) begin
            m_active[n] = 1'b1;
            m_next[n]   = edge_no + longint'(m_delay[n]) + 1;
         end else if (fire[n]) begin
            if (m_rpt[n]) m_next[n] = edge_no + longint'(m_delay[n]) + 1;
            else          m_active[n] = 1'b0;
         end
         if (fire[n])      m_flag[n] = 1'b1;
         else if (clr[n])  m_flag[n] = 1'b0;
      end
      m_events = fire;
      if (dly_we) begin
         m_delay[dly_ch] = 32'(parDo[15:0]);
         m_rpt[dly_ch]   = parDo[31];
      end
      if (ie_we) m_inten = parDo[N-1:0];
      edge_no++;
   endfunction

   function automatic void model_read(input logic [11:0] a, output bit hit, output logic [31:0] d);
      int unsigned ch;
      hit = 1'b0;
      d   = '0;
      if (addr_ch(a, 'h000, ch) || addr_ch(a, 'h080, ch)) begin
         hit = 1'b1;
      end else if (addr_ch(a, 'h100, ch)) begin
         hit = 1'b1;
         d   = {31'b0, m_flag[ch]};
      end else if (addr_ch(a, 'h200, ch)) begin
         hit = 1'b1;
         d   = {m_rpt[ch], 15'b0, 16'(m_delay[ch])};
      end else if (a == 12'h300) begin
         hit = 1'b1;
         d   = 32'(m_inten);
      end
   endfunction

   function automatic logic [11:0] rand_addr();
      int unsigned r;
      int unsigned ch;
      r  = $urandom_range(0, 5);
      ch = $urandom_range(0, N);
      case (r)
         0:       return 12'(32'h000 + 4 * ch);
         1:       return 12'(32'h080 + 4 * ch);
         2:       return 12'(32'h100 + 4 * ch);
         3:       return 12'(32'h200 + 4 * ch);
         4:       return ($urandom_range(0, 1) != 0) ? 12'h300 : 12'h304;
         default: return 12'(32'h200 + 4 * ch + 2);
      endcase
   endfunction

   // Advance one clock; outputs compared on the falling edge.
   task automatic step();
      @(posedge ck);
      model_edge();
      @(negedge ck);
      check("events", 32'(events), 32'(m_events));
      check("irq",    32'(irq),    32'(|(flag_vec() & m_inten)));
      check("busy",   32'(busy),   32'(any_active()));
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      parAddr = a;
      parDo   = d;
      parWe   = 4'($urandom_range(1, 15));
      step();
      parWe   = 4'h0;
      parDo   = '0;
   endtask

   task automatic rd(input string tag, input logic [11:0] a);
      bit          hit;
      logic [31:0] d;
      parAddr         = a;
      parRe           = 1'b1;
      parWe           = 4'h0;
      parDiMain       = $urandom;
      parDiSelectMain = 1'($urandom_range(0, 1));
      #1;
      model_read(a, hit, d);
      check({tag, " di"},  parDi, hit ? d : parDiMain);
      check({tag, " sel"}, 32'(parDiSelect), 32'(parDiSelectMain | hit));
      parRe           = 1'b0;
      parDiSelectMain = 1'b0;
   endtask

   task automatic rd_const(input string tag, input logic [11:0] a, input logic [31:0] exp);
      parAddr         = a;
      parRe           = 1'b1;
      parWe           = 4'h0;
      parDiMain       = 32'hDEAD_BEEF;
      parDiSelectMain = 1'b0;
      #1;
      check(tag, parDi, exp);
      check({tag, " sel"}, 32'(parDiSelect), 32'(1));
      parRe = 1'b0;
   endtask

   task automatic rd_unmapped(input string tag, input logic [11:0] a);
      parAddr         = a;
      parRe           = 1'b1;
      parWe           = 4'h0;
      parDiMain       = 32'hA5A5_1234;
      parDiSelectMain = 1'b0;
      #1;
      check(tag, parDi, 32'hA5A5_1234);
      check({tag, " sel"}, 32'(parDiSelect), 32'(0));
      parRe = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      int unsigned op;
      int unsigned ch;

      arst = 1'b1; parAddr = '0; parDo = '0; parRe = 1'b0; parWe = 4'h0;
      parDiMain = '0; parDiSelectMain = 1'b0; tasks = '0; tasksStop = '0; max_tasks = '0;
      model_reset();
      repeat (3) step();
      check("rst events", 32'(events), 32'(0));
      check("rst irq",    32'(irq),    32'(0));
      check("rst busy",   32'(busy),   32'(0));
      rd_const("rst delay0", 12'h200, 32'h0);
      rd_const("rst inten",  12'h300, 32'h0);
      rd_const("rst event0", 12'h100, 32'h0);
      arst = 1'b0;
      step();

      // Single shot, D=5: pulse six edges after the trigger edge.
      wr(12'h200, 32'd5);
      wr(12'h000, 32'h1);
      for (int i = 1; i <= 7; i++) begin
         step();
         check($sformatf("d5 ev0 k+%0d", i), 32'(events[0]), 32'(i == 6));
      end
      rd_const("d5 event0 flag", 12'h100, 32'h1);
      check("d5 irq masked", 32'(irq), 32'(0));
      rd_const("trigger reads 0", 12'h000, 32'h0);

      // D=0 with repeat: a pulse every cycle until stopped.
      wr(12'h208, 32'h8000_0000);
      tasks[2] = 1'b1;
      step();
      tasks = '0;
      check("rep ev2 trig edge", 32'(events[2]), 32'(0));
      for (int i = 0; i < 6; i++) begin
         step();
         check("rep ev2 running", 32'(events[2]), 32'(1));
      end
      tasksStop[2] = 1'b1;
      step();
      tasksStop = '0;
      for (int i = 0; i < 4; i++) begin
         check("rep ev2 stopped", 32'(events[2]), 32'(0));
         check("rep busy stopped", 32'(busy), 32'(0));
         step();
      end

      // Retrigger restarts the delay; only one pulse.
      wr(12'h204, 32'd10);
      wr(12'h004, 32'h1);
      repeat (3) step();
      wr(12'h004, 32'h1);
      for (int i = 1; i <= 11; i++) begin
         step();
         check($sformatf("retrig ev1 +%0d", i), 32'(events[1]), 32'(i == 11));
      end

      // Interrupt: flag set beats a same-cycle clear; later clears drop irq.
      wr(12'h300, 32'h8);
      wr(12'h20C, 32'd2);
      wr(12'h00C, 32'h1);
      for (int i = 1; i <= 3; i++) begin
         step();
         check($sformatf("irq ev3 +%0d", i), 32'(events[3]), 32'(i == 3));
      end
      check("irq high", 32'(irq), 32'(1));
      wr(12'h00C, 32'h1);
      step();
      step();
      wr(12'h10C, 32'h0);
      check("set beats clr ev3", 32'(events[3]), 32'(1));
      check("set beats clr irq", 32'(irq), 32'(1));
      rd_const("set beats clr flag", 12'h10C, 32'h1);
      wr(12'h10C, 32'h0);
      check("clr irq low", 32'(irq), 32'(0));
      rd_const("clr flag", 12'h10C, 32'h0);
      wr(12'h00C, 32'h1);
      repeat (3) step();
      check("irq high again", 32'(irq), 32'(1));
      wr(12'h300, 32'h0);
      check("inten clr irq", 32'(irq), 32'(0));
      rd_const("inten clr keeps flag", 12'h10C, 32'h1);

      // Trigger and stop together: stop wins.
      tasks[4] = 1'b1; tasksStop[4] = 1'b1;
      step();
      tasks = '0; tasksStop = '0;
      check("trig+stop busy", 32'(busy), 32'(0));
      tasksStop[4] = 1'b1;
      wr(12'h010, 32'h1);
      tasksStop = '0;
      check("swtrig+stop busy", 32'(busy), 32'(0));
      repeat (3) begin
         step();
         check("trig+stop no ev4", 32'(events[4]), 32'(0));
      end

      // DELAY field width: unused bits read 0, widest instance keeps all 31 bits.
      wr(12'h200, 32'hFFFF_FFFF);
      rd_const("delay0 mask", 12'h200, 32'h8000_FFFF);
      check("max delay0 full", max_di, 32'hFFFF_FFFF);
      wr(12'h200, 32'h0);
      wr(12'h27C, 32'h7FFF_FFFF);
      rd_unmapped("dut 27C unmapped", 12'h27C);
      parRe = 1'b1; #1;
      check("max delay31 rd", max_di, 32'h7FFF_FFFF);
      check("max delay31 sel", 32'(max_sel), 32'(1));
      parRe = 1'b0;
      wr(12'h07C, 32'h1);
      check("max busy run", 32'(max_busy), 32'(1));
      repeat (20) step();
      check("max no event", max_events, 32'h0);
      check("max busy still", 32'(max_busy), 32'(1));
      wr(12'h0FC, 32'h1);
      check("max busy stop", 32'(max_busy), 32'(0));

      // Randomized traffic against the model.
      for (int c = 0; c < 1500; c++) begin
         op = $urandom_range(0, 9);
         ch = $urandom_range(0, N - 1);
         for (int n = 0; n < N; n++) begin
            tasks[n]     = ($urandom_range(0, 15) == 0);
            tasksStop[n] = ($urandom_range(0, 63) == 0);
         end
         case (op)
            3, 9: begin
               rd("rnd rd", rand_addr());
               step();
            end
            4: begin
               d = $urandom;
               d[15:0] = 16'($urandom_range(0, 7));
               wr(12'(32'h200 + 4 * ch), d);
            end
            5: wr(12'(32'h000 + 4 * ch), $urandom);
            6: begin
               if ($urandom_range(0, 3) == 0) wr(12'(32'h080 + 4 * ch), $urandom);
               else step();
            end
            7: wr(12'(32'h100 + 4 * ch), $urandom);
            8: wr(12'h300, $urandom);
            default: step();
         endcase
         tasks = '0;
         tasksStop = '0;
      end

      // Asynchronous reset mid-count.
      wr(12'h214, 32'd8);
      wr(12'h300, 32'hFF);
      wr(12'h014, 32'h1);
      repeat (3) step();
      arst = 1'b1;
      #2;
      check("arst async busy",   32'(busy),   32'(0));
      check("arst async events", 32'(events), 32'(0));
      check("arst async irq",    32'(irq),    32'(0));
      step();
      arst = 1'b0;
      for (int i = 0; i < 30; i++) begin
         step();
         check("post-rst events", 32'(events), 32'(0));
      end
      check("post-rst busy",      32'(busy),      32'(0));
      check("post-rst max busy",  32'(max_busy),  32'(0));
      check("post-rst max irq",   32'(max_irq),   32'(0));
      check("post-rst max ev",    max_events,     32'h0);
      rd_const("post-rst inten", 12'h300, 32'h0);
      for (int n = 0; n < N; n++) begin
         rd_const($sformatf("post-rst delay%0d", n), 12'(32'h200 + 4 * n), 32'h0);
         rd_const($sformatf("post-rst event%0d", n), 12'(32'h100 + 4 * n), 32'h0);
      end
      rd_unmapped("post-rst unmapped 400", 12'h400);
      rd_unmapped("post-rst unmapped 304", 12'h304);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
